uart_rx: RTL and testbench
==========================

// Module: uart_rx
// PURPOSE
//  UART receiver; sits directly downstream of the UART baud/oversample clock generator.
//  Consumes that block's rx_clk output as a 1-clk-wide 16x-oversample enable (rx_tick).
//  Deserialises rxd into parallel bytes, checks stop and (optionally) parity bits.
//  Presents each byte on a valid/ready interface to the host/FIFO stage.
// PARAMETERS
//  OVERSAMPLE   16  rx_tick pulses per bit period; must be even, >= 8
//  SYNC_STAGES  2   flops in rxd synchroniser (>= 2)
// PORTS
//  clk          in   1  system clock
//  rstn         in   1  reset; asynchronous, active-low
//  rx_tick      in   1  oversample enable pulse, one clk wide, OVERSAMPLE x baud
//  rxd          in   1  serial line, asynchronous, idle high
//  data_len     in   2  00=5, 01=6, 10=7, 11=8 data bits
//  stop2        in   1  1 = two stop bits checked
//  parity_odd   in   1  1 = odd, 0 = even parity (only used with UART_PARITY_EN)
//  rx_data      out  8  received byte; bit i = i-th data bit (LSB first); unused MSBs 0
//  rx_valid     out  1  rx_data/errors valid; held until rx_ready
//  rx_ready     in   1  consumer accepts; handshake completes when rx_valid & rx_ready
//  frame_err    out  1  a checked stop bit sampled 0 (qualified by rx_valid)
//  parity_err   out  1  parity mismatch (qualified by rx_valid)
//  rx_overrun   out  1  1-clk pulse: new frame completed while rx_valid still high
// BEHAVIOUR
//  Reset: rstn, asynchronous, active-low; clock clk. All outputs 0; synchroniser flops reset to 1; FSM=IDLE.
//  rxd passes through SYNC_STAGES flops; FSM sees only the synchronised rxd_s.
//  FSM advances only on clk edges with rx_tick=1; with rx_tick=0 all state is frozen.
//  tick_cnt counts rx_tick pulses within a bit; sample point is tick_cnt==OVERSAMPLE/2-1 (start bit)
//  and tick_cnt==OVERSAMPLE-1 measured from the start-bit midpoint (all later bits).
//  IDLE:   rxd_s==0 on a tick -> START, tick_cnt=0.
//  START:  at mid-bit: rxd_s==1 -> IDLE (glitch rejected, no output); else latch data_len,
//          stop2, parity_odd into shadow regs, bit_cnt=0 -> DATA.
//  DATA:   sample every OVERSAMPLE ticks into shift reg; after data_len+5 bits -> PARITY or STOP1.
//  PARITY: sample bit; err = XOR(data bits, sample) != parity_odd.
//  STOP1:  sample; 0 sets frame_err_nxt; -> STOP2 if stop2 latched, else DONE.
//  STOP2:  sample; 0 sets frame_err_nxt; -> DONE.
//  DONE (1 clk, no tick needed): load rx_data/frame_err/parity_err, rx_valid=1, -> IDLE.
//   Return to IDLE at stop-bit midpoint permits back-to-back frames with resync on next start edge.
//  Handshake: rx_valid clears the cycle after rx_valid&rx_ready, unless DONE loads in that cycle.
//  DONE with rx_valid=1 and no ready in same cycle: outputs overwritten with new frame, rx_overrun pulses 1 clk.
//  DONE coincident with rx_ready: old byte consumed, new byte loaded, rx_valid stays 1, no overrun.
//  Config inputs changed mid-frame take effect at next start bit only.
//  Break (rxd low through stop): frame_err=1, rx_data=0; next frame needs rxd_s high then low.
// CONFIGURATION
//  UART_PARITY_EN defined: PARITY state present; parity bit expected between data and stop.
//  Not defined: no PARITY state, parity_odd ignored, parity_err tied 0.
// STRUCTURE
//  uart_pkg: rx state enum (IDLE,START,DATA,PARITY,STOP1,STOP2,DONE), data_len encoding,
//   UART_OVERSAMPLE default constant; shared with tx side.
//  One sub-module: uart_sync (SYNC_STAGES-deep synchroniser, reset value 1).
// TESTING (16x ticks every 4 clk unless noted)
//  8N1 byte 0xA5, rx_ready=1 -> one rx_valid, rx_data=0xA5, frame_err=0, parity_err=0.
//  rxd low for 4 ticks then high -> no rx_valid; next 0x5A frame received correctly.
//  8N1 0x3C with stop bit driven 0 -> rx_data=0x3C, frame_err=1.
//  UART_PARITY_EN, even, 0x3C with parity bit 1 -> parity_err=1; bit 0 -> parity_err=0.
//  0x11 then 0x22 back-to-back, rx_ready=0 -> rx_overrun pulse, rx_data=0x22.
//  data_len=00, 0x15 -> rx_data=0x15; rstn low mid-DATA -> all outputs 0, FSM IDLE.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, data-length encoding, oversample default.
package uart_pkg;

   localparam int unsigned UART_OVERSAMPLE = 16;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP1,
      STOP2,
      DONE
   } rx_state_e;

   typedef enum logic [1:0] {
      LEN_5 = 2'b00,
      LEN_6 = 2'b01,
      LEN_7 = 2'b10,
      LEN_8 = 2'b11
   } data_len_e;

   // Index of the final data bit for a given data_len encoding (5..8 bits -> 4..7).
   function automatic logic [2:0] last_bit_idx(input logic [1:0] len);
      return 3'(len) + 3'd4;
   endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Receive-side byte handshake between uart_rx (master) and the host/FIFO stage (slave).
interface uart_rx_if;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_ready;
   logic       frame_err;
   logic       parity_err;
   logic       rx_overrun;

   modport master (
      output rx_data, rx_valid, frame_err, parity_err, rx_overrun,
      input  rx_ready
   );

   modport slave (
      input  rx_data, rx_valid, frame_err, parity_err, rx_overrun,
      output rx_ready
   );
endinterface

// File: rtl/uart_sync.sv
// Multi-flop synchroniser for the asynchronous serial line; resets to the idle (high) level.
module uart_sync #(
   parameter int unsigned STAGES = 2
) (
   input  logic clk,
   input  logic rstn,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] ff;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) ff <= '1;
      else       ff <= {ff[STAGES-2:0], d};
   end

   assign q = ff[STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 16x-oversampled deserialiser with stop/parity checking and valid/ready output.
// Optional parity stage enabled by defining UART_PARITY_EN.
module uart_rx
   import uart_pkg::*;
#(
   parameter int unsigned OVERSAMPLE  = UART_OVERSAMPLE,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       rstn,
   input  logic       rx_tick,
   input  logic       rxd,
   input  logic [1:0] data_len,
   input  logic       stop2,
   input  logic       parity_odd,
   uart_rx_if.master  rx
);

   localparam int unsigned TW = $clog2(OVERSAMPLE);
   localparam logic [TW-1:0] MID_TICK  = TW'(OVERSAMPLE / 2 - 1);
   localparam logic [TW-1:0] FULL_TICK = TW'(OVERSAMPLE - 1);

   logic rxd_s;

   uart_sync #(.STAGES(SYNC_STAGES)) u_sync (
      .clk  (clk),
      .rstn (rstn),
      .d    (rxd),
      .q    (rxd_s)
   );

   rx_state_e     state, state_n;
   logic [TW-1:0] tick_cnt, tick_n;
   logic [2:0]    bit_cnt, bit_n;
   logic [7:0]    shreg, sh_n;
   logic [1:0]    len_q, len_n;
   logic          stop2_q, stop2_n;
   logic          podd_q, podd_n;
   logic          ferr_q, ferr_n;
   logic          perr_q, perr_n;
   logic          armed_q, armed_n;
   logic [7:0]    data_q, data_n;
   logic          valid_q, valid_n;
   logic          fo_q, fo_n;
   logic          po_q, po_n;
   logic          ovr_q, ovr_n;

   // State and datapath registers; everything is held unless the next-state logic changes it.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state    <= IDLE;
         tick_cnt <= '0;
         bit_cnt  <= '0;
         shreg    <= '0;
         len_q    <= '0;
         stop2_q  <= 1'b0;
         podd_q   <= 1'b0;
         ferr_q   <= 1'b0;
         perr_q   <= 1'b0;
         armed_q  <= 1'b1;
         data_q   <= '0;
         valid_q  <= 1'b0;
         fo_q     <= 1'b0;
         po_q     <= 1'b0;
         ovr_q    <= 1'b0;
      end else begin
         state    <= state_n;
         tick_cnt <= tick_n;
         bit_cnt  <= bit_n;
         shreg    <= sh_n;
         len_q    <= len_n;
         stop2_q  <= stop2_n;
         podd_q   <= podd_n;
         ferr_q   <= ferr_n;
         perr_q   <= perr_n;
         armed_q  <= armed_n;
         data_q   <= data_n;
         valid_q  <= valid_n;
         fo_q     <= fo_n;
         po_q     <= po_n;
         ovr_q    <= ovr_n;
      end
   end

   always_comb begin
      state_n = state;
      tick_n  = tick_cnt;
      bit_n   = bit_cnt;
      sh_n    = shreg;
      len_n   = len_q;
      stop2_n = stop2_q;
      podd_n  = podd_q;
      ferr_n  = ferr_q;
      perr_n  = perr_q;
      armed_n = armed_q;
      data_n  = data_q;
      valid_n = valid_q;
      fo_n    = fo_q;
      po_n    = po_q;
      ovr_n   = 1'b0;

      if (valid_q && rx.rx_ready) valid_n = 1'b0;

      unique case (state)
         // After a frame whose last stop bit was low, wait for the line to go high again.
         IDLE: if (rx_tick) begin
            if (rxd_s) begin
               armed_n = 1'b1;
            end else if (armed_q) begin
               state_n = START;
               tick_n  = '0;
            end
         end

         START: if (rx_tick) begin
            if (tick_cnt == MID_TICK) begin
               tick_n = '0;
               if (rxd_s) begin
                  state_n = IDLE;
               end else begin
                  state_n = DATA;
                  len_n   = data_len;
                  stop2_n = stop2;
                  podd_n  = parity_odd;
                  bit_n   = '0;
                  sh_n    = '0;
                  ferr_n  = 1'b0;
                  perr_n  = 1'b0;
               end
            end else begin
               tick_n = tick_cnt + TW'(1);
            end
         end

         DATA: if (rx_tick) begin
            if (tick_cnt == FULL_TICK) begin
               tick_n         = '0;
               sh_n[bit_cnt]  = rxd_s;
               bit_n          = bit_cnt + 3'd1;
               if (bit_cnt == last_bit_idx(len_q)) begin
`ifdef UART_PARITY_EN
                  state_n = PARITY;
`else
                  state_n = STOP1;
`endif
               end
            end else begin
               tick_n = tick_cnt + TW'(1);
            end
         end

`ifdef UART_PARITY_EN
         PARITY: if (rx_tick) begin
            if (tick_cnt == FULL_TICK) begin
               tick_n  = '0;
               perr_n  = ((^shreg) ^ rxd_s) != podd_q;
               state_n = STOP1;
            end else begin
               tick_n = tick_cnt + TW'(1);
            end
         end
`endif

         STOP1: if (rx_tick) begin
            if (tick_cnt == FULL_TICK) begin
               tick_n  = '0;
               armed_n = rxd_s;
               if (!rxd_s) ferr_n = 1'b1;
               state_n = stop2_q ? STOP2 : DONE;
            end else begin
               tick_n = tick_cnt + TW'(1);
            end
         end

         STOP2: if (rx_tick) begin
            if (tick_cnt == FULL_TICK) begin
               tick_n  = '0;
               armed_n = rxd_s;
               if (!rxd_s) ferr_n = 1'b1;
               state_n = DONE;
            end else begin
               tick_n = tick_cnt + TW'(1);
            end
         end

         // Publish the frame; an unconsumed previous byte is overwritten and flagged.
         DONE: begin
            data_n  = shreg;
            fo_n    = ferr_q;
`ifdef UART_PARITY_EN
            po_n    = perr_q;
`else
            po_n    = 1'b0;
`endif
            valid_n = 1'b1;
            ovr_n   = valid_q && !rx.rx_ready;
            state_n = IDLE;
         end

         default: state_n = IDLE;
      endcase
   end

`ifndef UART_PARITY_EN
   logic unused_parity;
   assign unused_parity = podd_q ^ perr_q;
`endif

   assign rx.rx_data    = data_q;
   assign rx.rx_valid   = valid_q;
   assign rx.frame_err  = fo_q;
   assign rx.parity_err = po_q;
   assign rx.rx_overrun = ovr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed scenarios plus random frames against a frame-level model.
module tb_uart_rx;
   import uart_pkg::*;

   localparam int unsigned OS       = 16;
   localparam int unsigned TICK_DIV = 4;
   localparam int unsigned BIT_CLKS = OS * TICK_DIV;

   typedef struct packed {
      logic [7:0] d;
      logic       fe;
      logic       pe;
   } exp_t;

   logic       clk = 1'b0;
   logic       rstn = 1'b0;
   logic       rx_tick = 1'b0;
   logic       rxd = 1'b1;
   logic [1:0] data_len = 2'b11;
   logic       stop2 = 1'b0;
   logic       parity_odd = 1'b0;

   uart_rx_if bus ();

   uart_rx #(.OVERSAMPLE(OS), .SYNC_STAGES(2)) dut (
      .clk        (clk),
      .rstn       (rstn),
      .rx_tick    (rx_tick),
      .rxd        (rxd),
      .data_len   (data_len),
      .stop2      (stop2),
      .parity_odd (parity_odd),
      .rx         (bus)
   );

   always #5 clk = ~clk;

   initial begin
      int c;
      c = 0;
      forever begin
         @(negedge clk);
         rx_tick = (c == int'(TICK_DIV) - 1);
         c = (c + 1) % int'(TICK_DIV);
      end
   end

   exp_t q[$];
   int   n_checks = 0;
   int   n_pass   = 0;
   int   ovr_cnt  = 0;
   bit   mon_en   = 1'b1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // Frame-level reference: what a correct receiver reports for the given line waveform.
   function automatic exp_t model(input logic [7:0] d, input logic [1:0] len, input logic s2,
                                  input logic po, input logic par_bit, input logic [1:0] stops);
      exp_t e;
      int   n;
      n    = 5 + int'(len);
      e.d  = d & 8'((1 << n) - 1);
      e.fe = !stops[0] || (s2 && !stops[1]);
`ifdef UART_PARITY_EN
      e.pe = par_bit != (logic'($countones(e.d) % 2) ^ po);
`else
      e.pe = 1'b0;
`endif
      return e;
   endfunction

   always @(negedge clk) begin
      exp_t e;
      if (bus.rx_overrun) ovr_cnt++;
      if (mon_en && rstn && bus.rx_valid && bus.rx_ready) begin
         if (q.size() == 0) begin
            check("spurious_valid", 32'd1, 32'd0);
         end else begin
            e = q.pop_front();
            check("rx_data", 32'(bus.rx_data), 32'(e.d));
            check("frame_err", 32'(bus.frame_err), 32'(e.fe));
            check("parity_err", 32'(bus.parity_err), 32'(e.pe));
         end
      end
   end

   task automatic bit_out(input logic b);
      rxd = b;
      repeat (BIT_CLKS) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] d, input logic [1:0] len, input logic s2,
                             input logic po, input logic flip, input logic [1:0] stops,
                             input int idle, input bit push);
      logic par_bit;
      data_len   = len;
      stop2      = s2;
      parity_odd = po;
      par_bit    = (logic'($countones(d & 8'((1 << (5 + int'(len))) - 1)) % 2) ^ po) ^ flip;
      if (push) q.push_back(model(d, len, s2, po, par_bit, stops));
      bit_out(1'b0);
      // Config changes after the start bit must not affect this frame.
      data_len   = 2'($urandom);
      stop2      = 1'($urandom);
      parity_odd = 1'($urandom);
      for (int i = 0; i < 5 + int'(len); i++) bit_out(d[i]);
`ifdef UART_PARITY_EN
      bit_out(par_bit);
`endif
      bit_out(stops[0]);
      if (s2) bit_out(stops[1]);
      for (int i = 0; i < idle; i++) bit_out(1'b1);
      rxd = 1'b1;
   endtask

   task automatic check_idle_outputs(input string pfx);
      check({pfx, "_valid"}, 32'(bus.rx_valid), 32'd0);
      check({pfx, "_data"}, 32'(bus.rx_data), 32'd0);
      check({pfx, "_ferr"}, 32'(bus.frame_err), 32'd0);
      check({pfx, "_perr"}, 32'(bus.parity_err), 32'd0);
      check({pfx, "_ovr"}, 32'(bus.rx_overrun), 32'd0);
   endtask

   initial begin
      int ovr0;
      int budget;
      logic [7:0] d;
      logic [1:0] len, stops;
      logic s2, po, flip, bad;

      bus.rx_ready = 1'b1;
      repeat (5) @(negedge clk);
      check_idle_outputs("reset");
      rstn = 1'b1;
      bit_out(1'b1);
      bit_out(1'b1);

      send_frame(8'hA5, 2'b11, 1'b0, 1'b0, 1'b0, 2'b11, 1, 1'b1);

      // Short low pulse must be rejected as a glitch.
      rxd = 1'b0;
      repeat (4 * TICK_DIV) @(negedge clk);
      rxd = 1'b1;
      repeat (2 * BIT_CLKS) @(negedge clk);
      send_frame(8'h5A, 2'b11, 1'b0, 1'b0, 1'b0, 2'b11, 1, 1'b1);

      send_frame(8'h3C, 2'b11, 1'b0, 1'b0, 1'b0, 2'b10, 1, 1'b1);
`ifdef UART_PARITY_EN
      send_frame(8'h3C, 2'b11, 1'b0, 1'b0, 1'b1, 2'b11, 1, 1'b1);
      send_frame(8'h3C, 2'b11, 1'b0, 1'b0, 1'b0, 2'b11, 1, 1'b1);
`endif
      send_frame(8'h00, 2'b11, 1'b0, 1'b0, 1'b0, 2'b00, 2, 1'b1);
      send_frame(8'hC3, 2'b10, 1'b1, 1'b1, 1'b0, 2'b11, 1, 1'b1);

      // Back-to-back frames with nobody consuming: second overwrites first and flags overrun.
      mon_en       = 1'b0;
      bus.rx_ready = 1'b0;
      ovr0         = ovr_cnt;
      send_frame(8'h11, 2'b11, 1'b0, 1'b0, 1'b0, 2'b11, 0, 1'b0);
      send_frame(8'h22, 2'b11, 1'b0, 1'b0, 1'b0, 2'b11, 1, 1'b0);
      check("ovr_valid", 32'(bus.rx_valid), 32'd1);
      check("ovr_data", 32'(bus.rx_data), 32'h22);
      check("ovr_ferr", 32'(bus.frame_err), 32'd0);
      check("ovr_pulses", 32'(ovr_cnt - ovr0), 32'd1);
      bus.rx_ready = 1'b1;
      @(negedge clk);
      bus.rx_ready = 1'b0;
      check("ovr_consumed", 32'(bus.rx_valid), 32'd0);
      bus.rx_ready = 1'b1;
      mon_en       = 1'b1;

      send_frame(8'h15, 2'b00, 1'b0, 1'b0, 1'b0, 2'b11, 1, 1'b1);

      // Reset in the middle of the data bits.
      data_len = 2'b00;
      bit_out(1'b0);
      bit_out(1'b1);
      bit_out(1'b0);
      rstn = 1'b0;
      @(negedge clk);
      check_idle_outputs("midrst");
      rxd  = 1'b1;
      rstn = 1'b1;
      bit_out(1'b1);
      bit_out(1'b1);
      send_frame(8'h96, 2'b11, 1'b0, 1'b0, 1'b0, 2'b11, 1, 1'b1);

      for (int k = 0; k < 20; k++) begin
         d     = 8'($urandom);
         len   = 2'($urandom);
         s2    = 1'($urandom);
         po    = 1'($urandom);
         flip  = ($urandom_range(0, 3) == 0);
         bad   = ($urandom_range(0, 4) == 0);
         stops = bad ? 2'($urandom_range(0, 2)) : 2'b11;
         send_frame(d, len, s2, po, flip, stops, bad ? 1 : int'($urandom_range(0, 1)), 1'b1);
      end
      bit_out(1'b1);

      budget = 0;
      while (q.size() != 0 && budget < 10 * int'(BIT_CLKS)) begin
         @(negedge clk);
         budget++;
      end
      check("drain", 32'(q.size()), 32'd0);
      check("overrun_total", 32'(ovr_cnt), 32'd1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
